// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: one registered one-hot grant among 8 requesters, held until release.
// Latency: a request sampled at edge k is granted after edge k; one idle cycle between grants.
// Backpressure: the owner holds the grant until done, request drop, or hold timeout.
module rr_arbiter8 #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arb_en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             hold_exp;
    logic             owner_rel;

    // Scan from ptr upward (mod N_REQ); the first asserted request wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Release causes: owner-driven (done / request drop) versus forced hold expiry.
    always_comb begin
        owner_rel = done || !req[grant_idx];
        hold_exp  = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
    end

    // Grant FSM with registered outputs; timeout only when expiry alone forces release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_en && found) begin
                        state       <= GRANT;
                        grant       <= N_REQ'(1) << winner;
                        grant_idx   <= winner;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (owner_rel || hold_exp) begin
                        state       <= IDLE;
                        grant       <= '0;
                        grant_idx   <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx + IDX_W'(1);
                        timeout     <= !owner_rel;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
